// File: rtl/mesh_term_fifo_bank.sv
// Bank of per-terminal show-ahead packet FIFOs feeding the mesh router terminal inputs,
// with broadcast replication, drop accounting, per-channel occupancy and a global flush.
module mesh_term_fifo_bank #(
    parameter int PCKG_SZ = 40,
    parameter int N_TERM  = 16,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 8,
    localparam int CH_W   = (N_TERM > 1) ? $clog2(N_TERM) : 1,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_push,
    input  logic [CH_W-1:0]           i_push_ch,
    input  logic                      i_push_bcast,
    input  logic [PCKG_SZ-1:0]        i_push_data,
    input  logic                      i_flush,
    input  logic [N_TERM-1:0]         i_pop,
    output logic [N_TERM-1:0]         o_pndng,
    output logic [N_TERM*PCKG_SZ-1:0] o_data_out,
    output logic [N_TERM-1:0]         o_full,
    output logic [N_TERM*CW-1:0]      o_count,
    output logic [CNT_W-1:0]          o_drop_cnt
);

    logic [N_TERM-1:0] w_lost;
    logic              w_ch_valid;
    logic              w_drop;
    logic [CNT_W-1:0]  r_drop_cnt;

    assign w_ch_valid = ({1'b0, i_push_ch} < (CH_W + 1)'(N_TERM));

    for (genvar g = 0; g < N_TERM; g++) begin : g_chan
        logic [PCKG_SZ-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]   r_wr_ptr;
        logic [PTR_W-1:0]   r_rd_ptr;
        logic [CW-1:0]      r_count;
        logic               w_target;
        logic               w_empty;
        logic               w_full;
        logic               w_pop_ok;
        logic               w_wr_ok;

        assign w_empty  = (r_count == '0);
        assign w_full   = (r_count == CW'(DEPTH));
        assign w_target = i_push && (i_push_bcast ? (i_push_ch != CH_W'(g))
                                                  : (i_push_ch == CH_W'(g)));
        assign w_pop_ok = i_pop[g] && !w_empty;
        // A full channel still accepts when its head leaves in the same cycle.
        assign w_wr_ok  = w_target && (!w_full || w_pop_ok);
        assign w_lost[g] = w_target && !w_wr_ok;

        // Storage is deliberately left out of reset; pointers define what is valid.
        always_ff @(posedge i_clk) begin
            if (w_wr_ok && !i_flush) begin
                r_mem[r_wr_ptr] <= i_push_data;
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr_ok) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop_ok) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_wr_ok && !w_pop_ok) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_wr_ok && w_pop_ok) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end

        assign o_pndng[g]                       = !w_empty;
        assign o_full[g]                        = w_full;
        assign o_count[g*CW +: CW]              = r_count;
        assign o_data_out[g*PCKG_SZ +: PCKG_SZ] = w_empty ? '0 : r_mem[r_rd_ptr];
    end

    // One increment per losing push cycle, however many copies were lost.
    assign w_drop = i_push && !i_flush &&
                    ((|w_lost) || (!i_push_bcast && !w_ch_valid));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_mesh_term_fifo_bank.sv
// Directed, table-driven bench for mesh_term_fifo_bank at its default parameters
// (16 channels, depth 8, 40-bit packets, 8-bit drop counter).
module tb_mesh_term_fifo_bank;

    logic          clock;
    logic          rstN;
    logic          push;
    logic [3:0]    pushCh;
    logic          pushBcast;
    logic [39:0]   pushData;
    logic          flush;
    logic [15:0]   pop;
    logic [15:0]   pndng;
    logic [639:0]  dataOut;
    logic [15:0]   full;
    logic [63:0]   count;
    logic [7:0]    dropCnt;

    int testsRun  = 0;
    int failCount = 0;

    typedef struct {
        logic        push;
        logic [3:0]  ch;
        logic        bcast;
        logic [39:0] data;
        logic        flush;
        logic [15:0] pop;
        logic [15:0] expPndng;
        logic [15:0] expFull;
        logic [3:0]  chkCh;
        logic [3:0]  expCount;
        logic [39:0] expData;
        logic [7:0]  expDrop;
    } vec_t;

    vec_t vecs[$];

    mesh_term_fifo_bank dut (
        .i_clk        (clock),
        .i_rst_n      (rstN),
        .i_push       (push),
        .i_push_ch    (pushCh),
        .i_push_bcast (pushBcast),
        .i_push_data  (pushData),
        .i_flush      (flush),
        .i_pop        (pop),
        .o_pndng      (pndng),
        .o_data_out   (dataOut),
        .o_full       (full),
        .o_count      (count),
        .o_drop_cnt   (dropCnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mkVec(logic p, logic [3:0] c, logic b, logic [39:0] d, logic f,
                                   logic [15:0] pp, logic [15:0] ePn, logic [15:0] eFu,
                                   logic [3:0] kc, logic [3:0] eCo, logic [39:0] eDa,
                                   logic [7:0] eDr);
        vec_t v;
        v.push = p; v.ch = c; v.bcast = b; v.data = d; v.flush = f; v.pop = pp;
        v.expPndng = ePn; v.expFull = eFu; v.chkCh = kc; v.expCount = eCo;
        v.expData = eDa; v.expDrop = eDr;
        return v;
    endfunction

    // Inputs are applied just after an edge, held across the next edge, then idled.
    task automatic applyStimulus(input logic p, input logic [3:0] c, input logic b,
                                 input logic [39:0] d, input logic f, input logic [15:0] pp);
        push = p; pushCh = c; pushBcast = b; pushData = d; flush = f; pop = pp;
        @(posedge clock);
        #1;
        push = 1'b0; pushBcast = 1'b0; flush = 1'b0; pop = '0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] chCount(input int ch);
        return count[ch*4 +: 4];
    endfunction

    function automatic logic [39:0] chData(input int ch);
        return dataOut[ch*40 +: 40];
    endfunction

    initial begin
        // Unicast, fill/overflow, full push+pop, drain, wrap, empty push+pop, empty pop.
        vecs.push_back(mkVec(1, 3, 0, 40'hA5, 0, 16'h0000, 16'h0008, 16'h0000, 3, 1, 40'hA5, 0));
        vecs.push_back(mkVec(0, 0, 0, 40'h00, 0, 16'h0008, 16'h0000, 16'h0000, 3, 0, 40'h00, 0));
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mkVec(1, 0, 0, 40'(k), 0, 16'h0000, 16'h0001,
                                 (k == 8) ? 16'h0001 : 16'h0000, 0, 4'(k), 40'h1, 0));
        end
        vecs.push_back(mkVec(1, 0, 0, 40'h09, 0, 16'h0000, 16'h0001, 16'h0001, 0, 8, 40'h1, 1));
        vecs.push_back(mkVec(1, 0, 0, 40'h55, 0, 16'h0001, 16'h0001, 16'h0001, 0, 8, 40'h2, 1));
        for (int m = 1; m <= 8; m++) begin
            vecs.push_back(mkVec(0, 0, 0, 40'h0, 0, 16'h0001,
                                 (m < 8) ? 16'h0001 : 16'h0000, 16'h0000, 0, 4'(8 - m),
                                 (m <= 6) ? 40'(m + 2) : ((m == 7) ? 40'h55 : 40'h0), 1));
        end
        for (int j = 0; j < 4; j++) begin
            vecs.push_back(mkVec(1, 0, 0, 40'(8'hC0 + j), 0, 16'h0000, 16'h0001, 16'h0000,
                                 0, 1, 40'(8'hC0 + j), 1));
            vecs.push_back(mkVec(0, 0, 0, 40'h0, 0, 16'h0001, 16'h0000, 16'h0000, 0, 0, 40'h0, 1));
        end
        vecs.push_back(mkVec(1, 2, 0, 40'h11, 0, 16'h0004, 16'h0004, 16'h0000, 2, 1, 40'h11, 1));
        vecs.push_back(mkVec(0, 0, 0, 40'h00, 0, 16'h0010, 16'h0004, 16'h0000, 4, 0, 40'h00, 1));
        vecs.push_back(mkVec(0, 0, 0, 40'h00, 0, 16'h0004, 16'h0000, 16'h0000, 2, 0, 40'h00, 1));

        rstN = 1'b0; push = 1'b0; pushCh = '0; pushBcast = 1'b0; pushData = '0;
        flush = 1'b0; pop = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset pndng", 64'(pndng), 64'h0);
        checkOutput("reset full", 64'(full), 64'h0);
        checkOutput("reset count", count, 64'h0);
        checkOutput("reset data zero", 64'(dataOut == '0), 64'h1);
        checkOutput("reset drop", 64'(dropCnt), 64'h0);
        rstN = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].push, vecs[i].ch, vecs[i].bcast, vecs[i].data,
                          vecs[i].flush, vecs[i].pop);
            checkOutput($sformatf("v%0d pndng", i), 64'(pndng), 64'(vecs[i].expPndng));
            checkOutput($sformatf("v%0d full", i), 64'(full), 64'(vecs[i].expFull));
            checkOutput($sformatf("v%0d count", i), 64'(chCount(int'(vecs[i].chkCh))),
                        64'(vecs[i].expCount));
            checkOutput($sformatf("v%0d data", i), 64'(chData(int'(vecs[i].chkCh))),
                        64'(vecs[i].expData));
            checkOutput($sformatf("v%0d drop", i), 64'(dropCnt), 64'(vecs[i].expDrop));
        end

        // Broadcast from ch5 while ch7 is full.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1, 7, 0, 40'(8'h70 + k), 0, 16'h0000);
        end
        checkOutput("ch7 full before bcast", 64'(full), 64'h0080);
        applyStimulus(1, 5, 1, 40'h3C, 0, 16'h0000);
        checkOutput("bcast pndng", 64'(pndng), 64'hFFDF);
        checkOutput("bcast full", 64'(full), 64'h0080);
        checkOutput("bcast ch0 data", 64'(chData(0)), 64'h3C);
        checkOutput("bcast ch15 count", 64'(chCount(15)), 64'h1);
        checkOutput("bcast ch5 count", 64'(chCount(5)), 64'h0);
        checkOutput("bcast ch5 data", 64'(chData(5)), 64'h0);
        checkOutput("bcast ch7 count", 64'(chCount(7)), 64'h8);
        checkOutput("bcast ch7 head", 64'(chData(7)), 64'h71);
        checkOutput("bcast drop", 64'(dropCnt), 64'h2);

        // Flush with a concurrent push.
        applyStimulus(1, 1, 0, 40'h99, 1, 16'h0000);
        checkOutput("flush pndng", 64'(pndng), 64'h0);
        checkOutput("flush count", count, 64'h0);
        checkOutput("flush full", 64'(full), 64'h0);
        checkOutput("flush data zero", 64'(dataOut == '0), 64'h1);
        checkOutput("flush drop kept", 64'(dropCnt), 64'h2);

        // Drop counter saturation.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1, 1, 0, 40'(k), 0, 16'h0000);
        end
        for (int k = 0; k < 252; k++) begin
            applyStimulus(1, 1, 0, 40'hFF, 0, 16'h0000);
        end
        checkOutput("drop at 254", 64'(dropCnt), 64'd254);
        for (int k = 0; k < 50; k++) begin
            applyStimulus(1, 1, 0, 40'hFF, 0, 16'h0000);
        end
        checkOutput("drop saturated", 64'(dropCnt), 64'd255);
        checkOutput("ch1 head kept", 64'(chData(1)), 64'h1);

        // Asynchronous reset mid-stream, checked before any further clock edge.
        applyStimulus(1, 9, 0, 40'hEE, 0, 16'h0000);
        checkOutput("pre-reset ch9 pndng", 64'(pndng), 64'h0202);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async reset pndng", 64'(pndng), 64'h0);
        checkOutput("async reset full", 64'(full), 64'h0);
        checkOutput("async reset count", count, 64'h0);
        checkOutput("async reset data zero", 64'(dataOut == '0), 64'h1);
        checkOutput("async reset drop", 64'(dropCnt), 64'h0);
        @(posedge clock);
        #1;
        rstN = 1'b1;
        applyStimulus(1, 6, 0, 40'h66, 0, 16'h0000);
        checkOutput("post-reset ch6 data", 64'(chData(6)), 64'h66);
        checkOutput("post-reset pndng", 64'(pndng), 64'h0040);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/mesh_term_fifo_bank.md
# mesh_term_fifo_bank

Parametrised bank of per-terminal packet FIFOs that feeds the mesh router's terminal inputs through the pending/pop handshake. It generalises the fixed 16-terminal interface to N_TERM channels of configurable depth and packet width. It adds broadcast replication, overflow accounting, per-channel occupancy and a global flush. It sits between the testbench driver/agent and the DUT `pndng_i_in`/`data_out_i_in`/`popin` terminals.

## Interface
- PCKG_SZ, 40, packet width in bits
- N_TERM, 16, number of terminal channels (≥2)
- DEPTH, 8, entries per channel FIFO (power of two, ≥2)
- CNT_W, 8, drop counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- push  in  1  write request for one packet
- push_ch  in  $clog2(N_TERM)  target channel; source channel when push_bcast=1
- push_bcast  in  1  replicate packet to every channel except push_ch
- push_data  in  PCKG_SZ  packet to write
- flush  in  1  synchronous clear of all FIFOs
- pop  in  N_TERM  per-channel pop from DUT
- pndng  out  N_TERM  channel non-empty
- data_out  out  N_TERM*PCKG_SZ  head packet of channel i at bits [i*PCKG_SZ +: PCKG_SZ]
- full  out  N_TERM  channel holds DEPTH entries
- count  out  N_TERM*$clog2(DEPTH+1)  per-channel occupancy, packed as data_out
- drop_cnt  out  CNT_W  saturating count of push cycles losing ≥1 copy

## Operation
- Each channel: circular buffer, wr/rd pointers $clog2(DEPTH) bits wrapping DEPTH-1→0, occupancy counter 0..DEPTH.
- Show-ahead: data_out slice = entry at rd pointer while pndng=1; all zeros when empty.
- Unicast (push=1, push_bcast=0): write to push_ch if not full, or if full and pop[push_ch]=1 same cycle; else drop.
- Broadcast (push=1, push_bcast=1): same acceptance rule evaluated independently per channel ≠ push_ch; push_ch untouched.
- Pop: honoured only when pndng[i]=1; pop on empty channel ignored, no underflow.
- Push+pop same channel same cycle: both performed, count unchanged; on empty channel push accepted, pop ignored.
- drop_cnt: +1 per push cycle where any target copy dropped (not per copy); saturates at 2^CNT_W-1.
- flush: pointers and counts of all channels to 0; overrides push and pop that cycle; drop_cnt retained.
- push_ch ≥ N_TERM with push_bcast=0: packet dropped, drop_cnt +1.

## Timing
- Reset (async assert, sync-style release on clk): pndng=0, full=0, count=0, data_out=0, drop_cnt=0; memory contents not cleared.
- Push at edge k → pndng/count/full/data_out updated after edge k (visible cycle k+1); latency 1 cycle.
- Pop at edge k → next entry (or zeros) presented after edge k; back-to-back pops drain one entry per cycle.
- Reset mid-operation: all in-flight state discarded immediately on reset low, no partial write.
- All outputs registered or decoded from registered state; no combinational path from push/pop to outputs.

## Test plan
- Reset, unicast push ch3 data 0xA5 → next cycle pndng=0x0008, count[3]=1, data_out[3]=0xA5; pop[3] → pndng=0, data_out[3]=0.
- Push 8 packets 1..8 to ch0 (DEPTH=8) → full[0]=1; 9th push 9 → dropped, drop_cnt=1; pops return 1..8 in order, pointer wrap verified with 4 more push/pop.
- Full ch0 with push 0x55 and pop[0] same cycle → head advances, count stays 8, 0x55 read last, drop_cnt unchanged.
- Broadcast from ch5 data 0x3C with ch7 full → all channels except 5 and 7 get 0x3C, ch7 unchanged, drop_cnt +1 once.
- Empty ch2 with push 0x11 and pop[2] same cycle → count[2]=1, data_out[2]=0x11; pop on empty ch4 → no change.
- Load 3 channels, assert flush with push to ch1 → all count=0, pndng=0, push ignored, drop_cnt preserved; reset low mid-stream clears all outputs asynchronously.
